// File: rtl/mem_bus_if.sv
// mem_bus_if: request/acknowledge data bus between the MEM stage and data memory
interface mem_bus_if;
  logic bus_req_o;
  logic bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0] bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic bus_ack_i;
  logic [31:0] bus_rdata_i;
  modport master(output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, input bus_ack_i, bus_rdata_i);
  modport slave(input bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, output bus_ack_i, bus_rdata_i);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage running one bus transaction per load/store and building the write-back bundle
module mem_stage #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [5:0]  stall,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq,
  output logic        misalign_o,
  mem_bus_if.master   bus
);
  localparam logic [7:0] LB = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5, LW = 8'hE3;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t st;
  logic [31:0] cap, ld, wdat_n;
  logic [15:0] h;
  logic [7:0] b;
  logic [3:0] sel_n;
  logic is_b, is_h, is_w, is_mem, is_st, mis, unused;
  assign unused = ^{stall[5], stall[3:0]};
  always_comb begin
    is_b = aluop_i inside {LB, LBU, SB};
    is_h = aluop_i inside {LH, LHU, SH};
    is_w = aluop_i inside {LW, SW};
    is_mem = is_b | is_h | is_w;
    is_st = aluop_i inside {SB, SH, SW};
    mis = ALIGN_CHECK && ((is_h && mem_addr_i[0]) || (is_w && |mem_addr_i[1:0]));
    sel_n = is_b ? 4'b1000 >> mem_addr_i[1:0] : is_h ? (mem_addr_i[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    wdat_n = is_b ? {4{reg2_i[7:0]}} : is_h ? {2{reg2_i[15:0]}} : reg2_i;
    b = 8'(cap >> {~mem_addr_i[1:0], 3'b000});
    h = mem_addr_i[1] ? cap[15:0] : cap[31:16];
    ld = aluop_i == LB ? {{24{b[7]}}, b} : aluop_i == LBU ? {24'b0, b} :
         aluop_i == LH ? {{16{h[15]}}, h} : aluop_i == LHU ? {16'b0, h} : cap;
    wd_o = rst ? '0 : wd_i;
    hi_o = rst ? '0 : hi_i;
    lo_o = rst ? '0 : lo_i;
    whilo_o = !rst && whilo_i;
    stallreq = !rst && (st == BUSY || (st == IDLE && is_mem && !mis));
    misalign_o = !rst && st == IDLE && is_mem && mis;
    wreg_o = !rst && wreg_i && (st == DONE || (st == IDLE && !is_mem));
    wdata_o = rst ? '0 : (st == DONE && is_mem && !is_st) ? ld : wdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      bus.bus_req_o <= 1'b0;
      bus.bus_we_o <= 1'b0;
      bus.bus_addr_o <= '0;
      bus.bus_sel_o <= '0;
      bus.bus_wdata_o <= '0;
      cap <= '0;
    end else begin
      case (st)
        IDLE: if (is_mem && !mis) begin
          st <= BUSY;
          bus.bus_req_o <= 1'b1;
          bus.bus_we_o <= is_st;
          bus.bus_addr_o <= {mem_addr_i[31:2], 2'b00};
          bus.bus_sel_o <= sel_n;
          bus.bus_wdata_o <= wdat_n;
        end
        BUSY: if (bus.bus_ack_i) begin
          st <= DONE;
          bus.bus_req_o <= 1'b0;
          bus.bus_we_o <= 1'b0;
          cap <= bus.bus_rdata_i;
        end
        DONE: if (!stall[4]) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized load/store/ALU traffic checked every cycle against a transaction-level model
module tb_mem_stage;
  localparam logic [7:0] LB = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5, LW = 8'hE3;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB, ADDU = 8'h21, ORR = 8'h25;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] wd = '0;
  logic wreg = 1'b0, whilo = 1'b0;
  logic [31:0] wdata = '0, hi = '0, lo = '0, addr = '0, reg2 = '0;
  logic [7:0] aluop = '0;
  logic [5:0] stall = '0;
  logic [4:0] y_wd, x_wd;
  logic y_wreg, y_whilo, y_stallreq, y_mis, x_wreg, x_whilo, x_stallreq, x_mis;
  logic [31:0] y_wdata, y_hi, y_lo, x_wdata, x_hi, x_lo;
  logic e_stall = 1'b0, e_wreg = 1'b0, e_mis = 1'b0, e_req = 1'b0, e_we = 1'b0;
  logic [31:0] e_wdata = '0, e_addr = '0, e_bwd = '0;
  logic [3:0] e_sel = '0;
  logic last_we = 1'b0, prev_req = 1'b0, done_wreg = 1'b0;
  logic [31:0] last_addr = '0, last_bwd = '0, done_wdata = '0;
  logic [3:0] last_sel = '0;
  int total = 0, bad = 0, req_rises = 0, stall_cnt = 0;
  mem_bus_if b0();
  mem_bus_if b1();
  always #5 clk = ~clk;
  mem_stage #(.ALIGN_CHECK(1'b1)) u0 (
    .clk(clk), .rst(rst), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata), .hi_i(hi), .lo_i(lo),
    .whilo_i(whilo), .aluop_i(aluop), .mem_addr_i(addr), .reg2_i(reg2), .stall(stall),
    .wd_o(y_wd), .wreg_o(y_wreg), .wdata_o(y_wdata), .hi_o(y_hi), .lo_o(y_lo), .whilo_o(y_whilo),
    .stallreq(y_stallreq), .misalign_o(y_mis), .bus(b0));
  mem_stage #(.ALIGN_CHECK(1'b0)) u1 (
    .clk(clk), .rst(rst), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata), .hi_i(hi), .lo_i(lo),
    .whilo_i(whilo), .aluop_i(aluop), .mem_addr_i(addr), .reg2_i(reg2), .stall(stall),
    .wd_o(x_wd), .wreg_o(x_wreg), .wdata_o(x_wdata), .hi_o(x_hi), .lo_o(x_lo), .whilo_o(x_whilo),
    .stallreq(x_stallreq), .misalign_o(x_mis), .bus(b1));
  always @(posedge clk) begin
    b1.bus_ack_i <= !rst && b1.bus_req_o && !b1.bus_ack_i;
    b1.bus_rdata_i <= $urandom;
  end
  function automatic int op_size(input logic [7:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW: return 4;
      default: return 0;
    endcase
  endfunction
  function automatic bit is_store(input logic [7:0] op);
    return op inside {SB, SH, SW};
  endfunction
  function automatic bit misaligned(input logic [7:0] op, input logic [31:0] a);
    return (op_size(op) == 2 && a[0]) || (op_size(op) == 4 && a[1:0] != 2'b00);
  endfunction
  function automatic int lane_off(input logic [7:0] op, input logic [31:0] a);
    return op_size(op) == 4 ? 0 : op_size(op) == 2 ? (a[1] ? 2 : 0) : int'(a[1:0]);
  endfunction
  function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] a);
    logic [3:0] s = '0;
    for (int k = lane_off(op, a); k < lane_off(op, a) + op_size(op); k++) s[3 - k] = 1'b1;
    return s;
  endfunction
  function automatic logic [31:0] model_wd(input logic [7:0] op, input logic [31:0] r);
    return op_size(op) == 1 ? {4{r[7:0]}} : op_size(op) == 2 ? {2{r[15:0]}} : r;
  endfunction
  function automatic logic [31:0] load_val(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v = '0;
    for (int k = 0; k < op_size(op); k++) v = (v << 8) | 32'(rd[31 - 8 * (lane_off(op, a) + k) -: 8]);
    if (op == LB && v[7]) v = v | 32'hFFFF_FF00;
    if (op == LH && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_stallreq", 32'(y_stallreq), 0);
      chk("rst_wreg", 32'(y_wreg), 0);
      chk("rst_wd", 32'(y_wd), 0);
      chk("rst_wdata", y_wdata, 0);
      chk("rst_hi", y_hi, 0);
      chk("rst_misalign", 32'(y_mis), 0);
    end else begin
      chk("wd", 32'(y_wd), 32'(wd));
      chk("hi", y_hi, hi);
      chk("lo", y_lo, lo);
      chk("whilo", 32'(y_whilo), 32'(whilo));
      chk("stallreq", 32'(y_stallreq), 32'(e_stall));
      chk("wreg", 32'(y_wreg), 32'(e_wreg));
      chk("wdata", y_wdata, e_wdata);
      chk("misalign", 32'(y_mis), 32'(e_mis));
      chk("bus_req", 32'(b0.bus_req_o), 32'(e_req));
      chk("bus_we", 32'(b0.bus_we_o), 32'(e_req & e_we));
      if (e_req) begin
        chk("bus_addr", b0.bus_addr_o, e_addr);
        chk("bus_sel", 32'(b0.bus_sel_o), 32'(e_sel));
        chk("bus_wdata", b0.bus_wdata_o, e_bwd);
      end
    end
    if (b0.bus_req_o) begin
      last_we = b0.bus_we_o;
      last_addr = b0.bus_addr_o;
      last_sel = b0.bus_sel_o;
      last_bwd = b0.bus_wdata_o;
    end
    if (b0.bus_req_o && !prev_req) req_rises++;
    prev_req = b0.bus_req_o;
    if (y_stallreq) stall_cnt++;
  end
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2, input logic [31:0] rd,
                        input int n, input int hold, input logic [4:0] d, input logic [31:0] wv, input logic wr);
    @(posedge clk); #1;
    aluop = op; addr = a; reg2 = r2; wd = d; wdata = wv;
    hi = $urandom; lo = $urandom; whilo = 1'($urandom);
    wreg = op_size(op) == 0 ? wr : !is_store(op);
    b0.bus_ack_i = 1'b0;
    e_req = 1'b0; e_mis = 1'b0; e_wdata = wv;
    if (op_size(op) == 0 || misaligned(op, a)) begin
      e_stall = 1'b0; e_mis = op_size(op) != 0; e_wreg = op_size(op) == 0 && wr; stall = '0;
      return;
    end
    e_stall = 1'b1; e_wreg = 1'b0; stall = 6'b011111;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      e_req = 1'b1; e_we = is_store(op); e_addr = {a[31:2], 2'b00};
      e_sel = model_sel(op, a); e_bwd = model_wd(op, r2);
      b0.bus_ack_i = i == n;
      b0.bus_rdata_i = i == n ? rd : $urandom;
    end
    for (int i = 0; i <= hold; i++) begin
      @(posedge clk); #1;
      b0.bus_ack_i = 1'b0; b0.bus_rdata_i = $urandom;
      e_req = 1'b0; e_stall = 1'b0; e_wreg = wreg;
      e_wdata = is_store(op) ? wv : load_val(op, a, rd);
      stall = i < hold ? 6'b011111 : 6'b000000;
      if (i == 0) begin
        @(negedge clk); #1;
        done_wdata = y_wdata; done_wreg = y_wreg;
      end
    end
  endtask
  initial begin
    logic [7:0] ops [10] = '{LB, LBU, LH, LHU, LW, SB, SH, SW, ADDU, ORR};
    int s0, r0;
    b0.bus_ack_i = 1'b0; b0.bus_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("post_reset_req", 32'(b0.bus_req_o), 0);
    run_op(ADDU, 0, 0, 0, 1, 0, 5'd3, 32'h1234, 1'b1);
    @(negedge clk); #1;
    chk("addu_wd", 32'(y_wd), 3);
    chk("addu_wdata", y_wdata, 32'h1234);
    chk("addu_stallreq", 32'(y_stallreq), 0);
    run_op(LW, 32'h6, 0, 0, 1, 0, 5'd4, 32'h77, 1'b1);
    @(negedge clk); #1;
    chk("lw6_misalign", 32'(y_mis), 1);
    chk("lw6_wreg", 32'(y_wreg), 0);
    chk("lw6_noalign_stall", 32'(x_stallreq), 1);
    run_op(ADDU, 0, 0, 0, 1, 0, 5'd1, 32'h0, 1'b0);
    @(negedge clk); #1;
    chk("lw6_noreq", 32'(b0.bus_req_o), 0);
    chk("lw6_noalign_req", 32'(b1.bus_req_o), 1);
    chk("lw6_noalign_addr", b1.bus_addr_o, 32'h4);
    chk("lw6_noalign_sel", 32'(b1.bus_sel_o), 32'hF);
    repeat (3) run_op(ORR, 0, 0, 0, 1, 0, 5'd2, 32'h5, 1'b1);
    s0 = stall_cnt;
    run_op(LB, 32'h101, 0, 32'h11F0_2233, 3, 0, 5'd8, 32'h9, 1'b1);
    chk("lb_sel", 32'(last_sel), 32'b0100);
    chk("lb_stall_cycles", stall_cnt - s0, 4);
    chk("lb_data", done_wdata, 32'hFFFF_FFF0);
    run_op(LBU, 32'h101, 0, 32'h11F0_2233, 2, 0, 5'd8, 32'h9, 1'b1);
    chk("lbu_data", done_wdata, 32'h0000_00F0);
    run_op(SH, 32'h202, 32'hAAAA_BEEF, 32'h0, 1, 0, 5'd0, 32'h202, 1'b0);
    chk("sh_we", 32'(last_we), 1);
    chk("sh_addr", last_addr, 32'h200);
    chk("sh_sel", 32'(last_sel), 32'b0011);
    chk("sh_wdata", last_bwd, 32'hBEEF_BEEF);
    chk("sh_wreg", 32'(done_wreg), 0);
    r0 = req_rises;
    run_op(LW, 32'h10, 0, 32'hCAFE_F00D, 2, 2, 5'd9, 32'h1, 1'b1);
    chk("lw_hold_data", done_wdata, 32'hCAFE_F00D);
    run_op(ADDU, 0, 0, 0, 1, 0, 5'd6, 32'h66, 1'b1);
    @(negedge clk); #1;
    chk("lw_hold_one_req", req_rises - r0, 1);
    chk("lw_hold_idle_stall", 32'(y_stallreq), 0);
    @(posedge clk); #1;
    aluop = LB; addr = 32'h300; wreg = 1'b1; stall = 6'b011111;
    e_stall = 1'b1; e_wreg = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_wdata = wdata;
    @(posedge clk); #1;
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h300; e_sel = 4'b1000; e_bwd = model_wd(LB, reg2);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_busy_req", 32'(b0.bus_req_o), 1);
    @(posedge clk); #1;
    rst = 1'b0; aluop = ADDU; wreg = 1'b0; stall = '0;
    e_stall = 1'b0; e_wreg = 1'b0; e_req = 1'b0; e_wdata = wdata;
    @(negedge clk); #1;
    chk("rst_mid_req", 32'(b0.bus_req_o), 0);
    chk("rst_mid_wreg", 32'(y_wreg), 0);
    @(posedge clk); #1;
    b0.bus_ack_i = 1'b1; b0.bus_rdata_i = $urandom;
    @(posedge clk); #1;
    b0.bus_ack_i = 1'b0;
    @(negedge clk); #1;
    chk("late_ack_req", 32'(b0.bus_req_o), 0);
    chk("late_ack_stall", 32'(y_stallreq), 0);
    for (int i = 0; i < 200; i++)
      run_op(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom, $urandom_range(1, 4), $urandom_range(0, 2),
             5'($urandom), $urandom, 1'($urandom));
    run_op(ADDU, 0, 0, 0, 1, 0, 5'd0, 32'h0, 1'b0);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs (destination, write data, HI/LO, aluop, memory address, store operand).
- Runs a request/acknowledge transaction on the data bus for load/store ops and raises stallreq to CTRL while a transaction is pending.
- Produces the write-back bundle for the MEM/WB register: load data extended per aluop, or non-memory results passed through unchanged.

Parameters:
- ALIGN_CHECK, 1, 1 = misaligned halfword/word accesses are suppressed and flagged; 0 = low address bits are ignored and the access is forced aligned.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high (`RstEnable)
- wd_i  input  5  destination register
- wreg_i  input  1  register write enable
- wdata_i  input  32  ALU result
- hi_i / lo_i  input  32 each  HI/LO values
- whilo_i  input  1  HI/LO write enable
- aluop_i  input  8  operation code; EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP are memory ops
- mem_addr_i  input  32  effective address
- reg2_i  input  32  store operand
- stall  input  6  CTRL stall vector; stall[4] = MEM stage hold
- wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o  output  5/1/32/32/32/1  to MEM/WB
- stallreq  output  1  pipeline stall request to CTRL
- misalign_o  output  1  one-cycle pulse: misaligned access suppressed
- bus_req_o  output  1  data bus request (registered)
- bus_we_o  output  1  1 = write (registered)
- bus_addr_o  output  32  word-aligned address, low two bits 00 (registered)
- bus_sel_o  output  4  byte lanes, big-endian, sel[3] = byte at addr 00 (registered)
- bus_wdata_o  output  32  store data (registered)
- bus_ack_i  input  1  slave acknowledge, one-cycle pulse
- bus_rdata_i  input  32  read data, valid when bus_ack_i = 1

Behaviour:
- Reset (rst = 1 at posedge):
  - state IDLE; all bus outputs 0; capture register 0.
  - All combinational outputs forced 0 while rst = 1 (wreg_o = `WriteDisable, wd_o = `NOPRegAddr).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Non-memory aluop: outputs = inputs; stallreq = 0.
  - Aligned memory op: stallreq = 1 combinationally; wreg_o = 0.
  - At the next edge: enter BUSY; bus_req_o = 1; bus_we_o = store; bus_addr_o = {addr[31:2], 2'b00}; sel and wdata loaded.
  - bus_ack_i is ignored in IDLE.
- Byte lanes:
  - Byte access: sel = 1000 >> addr[1:0]; wdata = {4{reg2[7:0]}}.
  - Halfword access: sel = 1100 (addr[1] = 0) or 0011 (addr[1] = 1); wdata = {2{reg2[15:0]}}.
  - Word access: sel = 1111.
- BUSY:
  - stallreq = 1; bus outputs held stable until ack.
  - On bus_ack_i at an edge: capture bus_rdata_i; bus_req_o = 0 and bus_we_o = 0 next cycle; enter DONE.
  - Minimum latency: op arrives cycle 0, request in cycles 1..n, DONE at n+1.
  - No timeout.
- DONE:
  - stallreq = 0.
  - Load: wdata_o = captured lane; LB/LH sign-extend, LBU/LHU zero-extend; wreg_o = wreg_i.
  - Store: wreg_o = wreg_i (0 from EX).
  - Return to IDLE at an edge where stall[4] = `NoStop.
  - While stall[4] = `Stop, stay in DONE and hold the outputs. This prevents re-issuing an access on the same instruction.
- Misaligned access with ALIGN_CHECK = 1 (halfword with addr[0] = 1, or word with addr[1:0] ≠ 00):
  - No bus request; stallreq = 0; wreg_o = 0; misalign_o = 1 for that cycle.
- HI/LO signals always pass through, in every state.
- Reset mid-transaction: back to IDLE, request dropped; a late ack is ignored.
- Back-to-back memory ops: each takes a full IDLE→BUSY→DONE sequence.
- Single outstanding request; the slave must not ack without a request.

Test Plan:
- Reset with bus_req_o = 1 in BUSY → next cycle state IDLE, bus_req_o = 0, wreg_o = 0; an ack 2 cycles later has no effect.
- ADDU-type op (wd = 3, wdata = 0x1234) → same-cycle outputs wd_o = 3, wdata_o = 0x1234, stallreq = 0, no bus request.
- LB at addr 0x101, ack after 3 cycles with rdata = 0x11F0_2233 → sel = 0100, stallreq high 4 cycles, wdata_o = 0xFFFF_FFF0; LBU with the same data → 0x0000_00F0.
- SH at addr 0x202, reg2 = 0xAAAA_BEEF, immediate ack → bus_we_o = 1, addr 0x200, sel = 0011, wdata = 0xBEEF_BEEF, wreg_o = 0.
- LW at addr 0x6 → misalign_o = 1 pulse, no request, wreg_o = 0; with ALIGN_CHECK = 0 → request to 0x4, sel = 1111.
- LW completes while stall[4] held at `Stop for 2 extra cycles → state stays DONE, exactly one request issued, wdata_o stable; IDLE after stall[4] = `NoStop.
